// File: rtl/axi_lite_uart_tx.sv
// axi_lite_uart_tx: AXI4-Lite slave feeding a TX FIFO drained as 8N1 serial frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame, STATUS bit 3 set).
module axi_lite_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [12:0] TXDATA_ADDR  = 13'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [12:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        sout,
    output logic        tx_busy
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam int          CW          = $clog2(CLKS_PER_BIT);
    localparam logic [12:0] STATUS_ADDR = TXDATA_ADDR + 13'd4;
    localparam logic [1:0]  OKAY        = 2'b00;
    localparam logic [1:0]  SLVERR      = 2'b10;
`ifdef UART_TX_PARITY_EN
    localparam logic        PAR_EN      = 1'b1;
`else
    localparam logic        PAR_EN      = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          sout_q, sout_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]   rdata_q, rdata_d, status;
    logic          wr_hs, rd_hs, wr_tx, push, pop, empty, full, last;
    logic          unused_bits;

    assign unused_bits = ^{wdata[31:8], wstrb[3:1]};

    assign empty   = count_q == '0;
    assign full    = count_q == (AW+1)'(FIFO_DEPTH);
    assign tx_busy = !empty || state_q != IDLE;
    assign last    = cnt_q == CW'(CLKS_PER_BIT - 1);

    assign wr_hs   = awvalid && wvalid && !bvalid_q && !rst;
    assign rd_hs   = arvalid && !rvalid_q && !rst;
    assign awready = wr_hs;
    assign wready  = wr_hs;
    assign arready = rd_hs;
    assign wr_tx   = awaddr == TXDATA_ADDR;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the byte.
    assign push    = wr_hs && wr_tx && wstrb[0] && (!full || pop);
    assign status  = {16'h0, 8'(count_q), 4'h0, PAR_EN, tx_busy, empty, full};

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rresp  = rresp_q;
    assign rdata  = rdata_q;
    assign sout   = sout_q;

    always_comb begin
        bvalid_d = wr_hs || (bvalid_q && !bready);
        bresp_d  = !wr_hs ? bresp_q :
                   (!wr_tx || (wstrb[0] && full && !pop)) ? SLVERR : OKAY;
        rvalid_d = rd_hs || (rvalid_q && !rready);
        rdata_d  = !rd_hs ? rdata_q : (araddr == STATUS_ADDR) ? status : 32'h0;
        rresp_d  = !rd_hs ? rresp_q :
                   (araddr == STATUS_ADDR || araddr == TXDATA_ADDR) ? OKAY : SLVERR;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    state_d = START;
                    pop     = 1'b1;
                    byte_d  = mem_q[rd_ptr_q];
                end
            end
            START: if (last) begin
                state_d = DATA;
                bit_d   = 3'd0;
            end
            DATA: if (last) begin
                bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
            PARITY: if (last) state_d = STOP;
            STOP: if (last) begin
                // Chain straight into the next start bit so queued frames have no idle gap.
                if (!empty) begin
                    state_d = START;
                    pop     = 1'b1;
                    byte_d  = mem_q[rd_ptr_q];
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        sout_d = (state_d == START)  ? 1'b0 :
                 (state_d == DATA)   ? byte_d[bit_d] :
                 (state_d == PARITY) ? ^byte_d : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 8'h0;
            sout_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= OKAY;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            sout_q   <= sout_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_uart_tx.sv
// tb_axi_lite_uart_tx: vector table plus hand sequences; serial frames checked against a byte scoreboard.
module tb_axi_lite_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int          FB  = 10 + PAR;
    localparam logic [12:0] TXA = 13'h1000;
    localparam logic [12:0] STA = 13'h1004;

    logic        clk = 1'b0, rst;
    logic [12:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, sout, tx_busy;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int         n_tests = 0, n_fail = 0, cyc = 0;
    logic [7:0] exp_q[$];
    bit         skip_frame = 1'b0;

    axi_lite_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TXDATA_ADDR(TXA)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .sout(sout), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input int cnt, input logic busy, input logic emp, input logic fl);
        return {16'h0, 8'(cnt), 4'h0, PAR != 0, busy, emp, fl};
    endfunction

    task automatic axi_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int k = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        while (!awready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("aw_handshake", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_rise", bvalid, 1);
        resp = bresp;
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] resp);
        int k = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        while (!arready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ar_handshake", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid_rise", rvalid, 1);
        d = rdata; resp = rresp;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] exp_resp, input string name);
        logic [1:0] r;
        axi_write(TXA, {24'h0, b}, 4'h1, r);
        check(name, r, exp_resp);
        if (exp_resp == 2'b00) exp_q.push_back(b);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k = 0;
        while (tx_busy && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, tx_busy, 0);
    endtask

    // Serial decoder: samples mid-bit and compares each frame with the scoreboard head.
    initial begin
        logic [7:0] b, e;
        logic p, stp;
        forever begin
            @(negedge clk);
            if (!rst && sout === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = sout;
                end
                p = 1'b0;
                if (PAR != 0) begin
                    repeat (CPB) @(negedge clk);
                    p = sout;
                end
                repeat (CPB) @(negedge clk);
                stp = sout;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mon_extra: got byte %h expected none", b);
                end else begin
                    e = exp_q.pop_front();
                    if (skip_frame) skip_frame = 1'b0;
                    else check("mon_frame", {stp, p, b}, {1'b1, (PAR != 0) ? ^e : 1'b0, e});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    initial begin
        vec_t        vt[8];
        logic [31:0] rd;
        logic [1:0]  r;
        logic        fbits[11];
        logic        act;
        int          c0;
        vt[0] = '{1'b0, STA,      32'h0,  4'h0, st(0, 0, 1, 0), 2'b00};
        vt[1] = '{1'b0, TXA,      32'h0,  4'h0, 32'h0,          2'b00};
        vt[2] = '{1'b0, 13'h0800, 32'h0,  4'h0, 32'h0,          2'b10};
        vt[3] = '{1'b1, 13'h0800, 32'h33, 4'h1, 32'h0,          2'b10};
        vt[4] = '{1'b1, TXA,      32'h77, 4'h0, 32'h0,          2'b00};
        vt[5] = '{1'b1, STA,      32'h55, 4'h1, 32'h0,          2'b10};
        vt[6] = '{1'b0, STA,      32'h0,  4'h0, st(0, 0, 1, 0), 2'b00};
        vt[7] = '{1'b0, 13'h1FFC, 32'h0,  4'h0, 32'h0,          2'b10};

        rst = 1'b1; awaddr = '0; wdata = '0; wstrb = '0; bready = 1'b1;
        araddr = '0; rready = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", {awready, wready, arready}, 3'b000);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_values", {bvalid, rvalid, bresp, rresp, rdata, sout, tx_busy},
              {1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b1, 1'b0});

        for (int i = 0; i < 8; i++) begin
            if (vt[i].wr) begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb, r);
                check($sformatf("vec%0d_bresp", i), r, vt[i].exp_resp);
            end else begin
                axi_read(vt[i].addr, rd, r);
                check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
                check($sformatf("vec%0d_rresp", i), r, vt[i].exp_resp);
            end
        end

        // 0x41: exact sout waveform starting two cycles after the handshake
        send(8'h41, 2'b00, "wr41_bresp");
        fbits[0] = 1'b0;
        for (int i = 0; i < 8; i++) fbits[i + 1] = (8'h41 >> i) & 8'h1;
        fbits[9] = 1'b0;
        fbits[FB - 1] = 1'b1;
        for (int i = 0; i < FB; i++) begin
            act = fbits[i];
            for (int c = 0; c < CPB; c++) begin
                if (sout !== fbits[i]) act = sout;
                @(posedge clk); #1;
            end
            check($sformatf("sout_bit%0d", i), act, fbits[i]);
        end
        check("busy_after_stop", tx_busy, 0);

        // "Hi\n": contiguous frames, busy drops exactly three frames after the first start bit
        c0 = cyc;
        send(8'h48, 2'b00, "hi_bresp0");
        send(8'h69, 2'b00, "hi_bresp1");
        send(8'h0A, 2'b00, "hi_bresp2");
        axi_read(STA, rd, r);
        check("status_3queued", rd, st(2, 1, 0, 0));
        wait_idle(1000, "hi_idle");
        check("hi_no_gap", cyc - c0, 2 + 3 * FB * CPB);

        // bready held low: response holds and no second handshake occurs
        awaddr = TXA; wdata = 32'h5A; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        check("hold_handshake", {awready, wready}, 2'b11);
        @(posedge clk); #1;
        exp_q.push_back(8'h5A);
        for (int i = 0; i < 5; i++) begin
            check("hold_bvalid", {bvalid, bresp}, 3'b100);
            @(negedge clk);
            check("hold_no_ready", {awready, wready}, 2'b00);
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        check("hold_bvalid_clear", bvalid, 0);
        wait_idle(200, "hold_idle");

        // Overflow: one byte in the serializer plus DEPTH in the FIFO, the next is refused
        for (int i = 0; i < DEPTH + 2; i++)
            send(8'(8'hA0 + i), (i < DEPTH + 1) ? 2'b00 : 2'b10, $sformatf("ovf_bresp%0d", i));
        axi_read(STA, rd, r);
        check("status_full", rd, st(DEPTH, 1, 0, 1));
        wait_idle((DEPTH + 2) * FB * CPB, "ovf_idle");

        // Reset in the middle of DATA bit 3 of 0x55 (a zero bit)
        send(8'h55, 2'b00, "rst_wr_bresp");
        skip_frame = 1'b1;
        repeat (18) begin
            @(posedge clk); #1;
        end
        check("pre_rst_sout", sout, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_sout_high", {sout, tx_busy}, 2'b10);
        axi_read(STA, rd, r);
        check("rst_status", rd, st(0, 0, 1, 0));
        repeat (60) begin
            @(posedge clk); #1;
        end
        send(8'h41, 2'b00, "post_rst_bresp");
        wait_idle(200, "post_rst_idle");

        repeat (10) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
